// File: rtl/y86_fetch_decode_wb.sv
// y86_fetch_decode_wb
//   Y86-64 SEQ front end. Fetch splits the 10-byte instruction window into its
//   fields. Decode reads the register file. Writeback updates the register file
//   with valE/valM on the rising clock edge.
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset of the register file
//   PC                          address of the current instruction
//   current_instruction[0:79]   bytes PC..PC+9, byte PC in bits [0:7]
//   cnd                         condition from execute; gates the cmovXX write
//   valE, valM                  ALU result and memory read data to write back
//   icode/ifun/rA/rB/valC/valP  fetched fields and next sequential PC
//   halt_prog, is_instruction_valid, pcvalid   status flags (pcvalid=1: PC out of range)
//   valA, valB                  decoded register operands
//   register_memory0..14        live register contents (%rax..%r14)
module y86_fetch_decode_wb #(
  parameter logic [63:0] IMEM_LIMIT = 64'd1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic        [63:0] PC,
  input  logic        [0:79] current_instruction,
  input  logic               cnd,
  input  logic signed [63:0] valE,
  input  logic signed [63:0] valM,
  output logic        [3:0]  icode,
  output logic        [3:0]  ifun,
  output logic        [3:0]  rA,
  output logic        [3:0]  rB,
  output logic        [63:0] valC,
  output logic        [63:0] valP,
  output logic               halt_prog,
  output logic               is_instruction_valid,
  output logic               pcvalid,
  output logic signed [63:0] valA,
  output logic signed [63:0] valB,
  output logic        [63:0] register_memory0,
  output logic        [63:0] register_memory1,
  output logic        [63:0] register_memory2,
  output logic        [63:0] register_memory3,
  output logic        [63:0] register_memory4,
  output logic        [63:0] register_memory5,
  output logic        [63:0] register_memory6,
  output logic        [63:0] register_memory7,
  output logic        [63:0] register_memory8,
  output logic        [63:0] register_memory9,
  output logic        [63:0] register_memory10,
  output logic        [63:0] register_memory11,
  output logic        [63:0] register_memory12,
  output logic        [63:0] register_memory13,
  output logic        [63:0] register_memory14
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [63:0] r_regs [0:14];

  logic [7:0]  w_byte [0:9];
  logic [63:0] w_c_b2;   // bytes 2..9, little-endian
  logic [63:0] w_c_b1;   // bytes 1..8, little-endian
  logic [3:0]  w_srcA, w_srcB, w_dstE, w_dstM;
  logic        w_wr_ok;

  // Slicing the ascending [0:79] vector keeps bit 8k as the MSB of byte k.
  always_comb begin
    for (int unsigned k = 0; k < 10; k++) begin
      w_byte[k] = current_instruction[8*k +: 8];
    end
    w_c_b2 = '0;
    w_c_b1 = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_c_b2[8*k +: 8] = w_byte[k+2];
      w_c_b1[8*k +: 8] = w_byte[k+1];
    end
  end

  // Fetch
  always_comb begin
    icode                = w_byte[0][7:4];
    ifun                 = w_byte[0][3:0];
    rA                   = RNONE;
    rB                   = RNONE;
    valC                 = '0;
    valP                 = PC + 64'd1;
    is_instruction_valid = 1'b1;
    case (icode)
      I_HALT, I_NOP, I_RET: valP = PC + 64'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        rA   = w_byte[1][7:4];
        rB   = w_byte[1][3:0];
        valP = PC + 64'd2;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        rA   = w_byte[1][7:4];
        rB   = w_byte[1][3:0];
        valC = w_c_b2;
        valP = PC + 64'd10;
      end
      I_JXX, I_CALL: begin
        valC = w_c_b1;
        valP = PC + 64'd9;
      end
      default: is_instruction_valid = 1'b0;
    endcase
  end

  assign halt_prog = (icode == I_HALT);
  assign pcvalid   = (PC > IMEM_LIMIT);
  assign w_wr_ok   = is_instruction_valid && !halt_prog;

  // Decode: register selection
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (icode)
      I_RRMOVQ: begin
        w_srcA = rA;
        if (cnd) w_dstE = rB;
      end
      I_IRMOVQ: w_dstE = rB;
      I_RMMOVQ: begin
        w_srcA = rA;
        w_srcB = rB;
      end
      I_MRMOVQ: begin
        w_srcB = rB;
        w_dstM = rA;
      end
      I_OPQ: begin
        w_srcA = rA;
        w_srcB = rB;
        w_dstE = rB;
      end
      I_CALL: begin
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      I_RET: begin
        w_srcA = RRSP;
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      I_PUSHQ: begin
        w_srcA = rA;
        w_srcB = RRSP;
        w_dstE = RRSP;
      end
      I_POPQ: begin
        w_srcA = RRSP;
        w_srcB = RRSP;
        w_dstE = RRSP;
        w_dstM = rA;
      end
      default: ;
    endcase
  end

  always_comb begin
    valA = (w_srcA == RNONE) ? '0 : r_regs[w_srcA];
    valB = (w_srcB == RNONE) ? '0 : r_regs[w_srcB];
  end

  // Writeback: the dstM assignment comes last so valM wins on a shared index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      if (w_dstE != RNONE) r_regs[w_dstE] <= valE;
      if (w_dstM != RNONE) r_regs[w_dstM] <= valM;
    end
  end

  assign register_memory0  = r_regs[0];
  assign register_memory1  = r_regs[1];
  assign register_memory2  = r_regs[2];
  assign register_memory3  = r_regs[3];
  assign register_memory4  = r_regs[4];
  assign register_memory5  = r_regs[5];
  assign register_memory6  = r_regs[6];
  assign register_memory7  = r_regs[7];
  assign register_memory8  = r_regs[8];
  assign register_memory9  = r_regs[9];
  assign register_memory10 = r_regs[10];
  assign register_memory11 = r_regs[11];
  assign register_memory12 = r_regs[12];
  assign register_memory13 = r_regs[13];
  assign register_memory14 = r_regs[14];

endmodule

// File: tb/tb_y86_fetch_decode_wb.sv
module tb_y86_fetch_decode_wb;

  logic               clk;
  logic               rst_n;
  logic        [63:0] PC;
  logic        [0:79] current_instruction;
  logic               cnd;
  logic signed [63:0] valE, valM;
  logic        [3:0]  icode, ifun, rA, rB;
  logic        [63:0] valC, valP;
  logic               halt_prog, is_instruction_valid, pcvalid;
  logic signed [63:0] valA, valB;
  logic        [63:0] rm [0:14];

  int errors = 0;
  int checks = 0;

  y86_fetch_decode_wb #(.IMEM_LIMIT(64'd1023)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .current_instruction(current_instruction),
    .cnd(cnd), .valE(valE), .valM(valM),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .halt_prog(halt_prog), .is_instruction_valid(is_instruction_valid), .pcvalid(pcvalid),
    .valA(valA), .valB(valB),
    .register_memory0(rm[0]), .register_memory1(rm[1]), .register_memory2(rm[2]),
    .register_memory3(rm[3]), .register_memory4(rm[4]), .register_memory5(rm[5]),
    .register_memory6(rm[6]), .register_memory7(rm[7]), .register_memory8(rm[8]),
    .register_memory9(rm[9]), .register_memory10(rm[10]), .register_memory11(rm[11]),
    .register_memory12(rm[12]), .register_memory13(rm[13]), .register_memory14(rm[14])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply a new instruction, then let combinational logic settle.
  task automatic apply(input logic [63:0] pc, input logic [0:79] ins,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    PC = pc; current_instruction = ins; cnd = c; valE = e; valM = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(64'd0, 80'h30F2_0000000000000000, 1'b0, 64'hDEAD, 64'h0);
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (rm[i] !== 64'd0) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, rm[i], 64'd0);
      end
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_fetch_lengths();
    apply(64'd1, 80'h1000_0000000000000000, 1'b0, 64'h0, 64'h0);
    checks++; if (valP !== 64'd2) begin errors++; $display("FAIL nop_valP got=%h exp=%h", valP, 64'd2); end
    checks++; if ({icode, rA, rB} !== 12'h1FF) begin errors++; $display("FAIL nop_fields got=%h exp=%h", {icode, rA, rB}, 12'h1FF); end
    checks++; if (valC !== 64'd0) begin errors++; $display("FAIL nop_valC got=%h exp=%h", valC, 64'd0); end

    apply(64'd2, 80'h2001_0000000000000000, 1'b0, 64'h0, 64'h0);
    checks++; if ({rA, rB} !== 8'h01) begin errors++; $display("FAIL rrmov_regs got=%h exp=%h", {rA, rB}, 8'h01); end
    checks++; if (valP !== 64'd4) begin errors++; $display("FAIL rrmov_valP got=%h exp=%h", valP, 64'd4); end

    apply(64'h100, 80'h30F3_EFCDAB8967452301, 1'b0, 64'h0, 64'h0);
    checks++; if (valC !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL irmov_valC got=%h exp=%h", valC, 64'h0123456789ABCDEF); end
    checks++; if (valP !== 64'h10A) begin errors++; $display("FAIL irmov_valP got=%h exp=%h", valP, 64'h10A); end
    checks++; if ({rA, rB} !== 8'hF3) begin errors++; $display("FAIL irmov_regs got=%h exp=%h", {rA, rB}, 8'hF3); end

    apply(64'h200, 80'h7311_2233445566778899, 1'b0, 64'h0, 64'h0);
    checks++; if (valC !== 64'h8877665544332211) begin errors++; $display("FAIL jxx_valC got=%h exp=%h", valC, 64'h8877665544332211); end
    checks++; if (valP !== 64'h209) begin errors++; $display("FAIL jxx_valP got=%h exp=%h", valP, 64'h209); end
    checks++; if ({ifun, rA, rB} !== 12'h3FF) begin errors++; $display("FAIL jxx_fields got=%h exp=%h", {ifun, rA, rB}, 12'h3FF); end
  endtask

  task automatic test_invalid_halt_range();
    apply(64'h40, 80'hC012_0000000000000000, 1'b0, 64'h0, 64'h0);
    checks++; if (is_instruction_valid !== 1'b0) begin errors++; $display("FAIL invalid_flag got=%b exp=%b", is_instruction_valid, 1'b0); end
    checks++; if (valP !== 64'h41) begin errors++; $display("FAIL invalid_valP got=%h exp=%h", valP, 64'h41); end

    apply(64'h50, 80'h0000_0000000000000000, 1'b0, 64'h0, 64'h0);
    checks++; if ({halt_prog, is_instruction_valid} !== 2'b11) begin errors++; $display("FAIL halt_flags got=%b exp=%b", {halt_prog, is_instruction_valid}, 2'b11); end

    apply(64'd1023, 80'h1000_0000000000000000, 1'b0, 64'h0, 64'h0);
    checks++; if (pcvalid !== 1'b0) begin errors++; $display("FAIL pc1023 got=%b exp=%b", pcvalid, 1'b0); end
    apply(64'd1024, 80'h1000_0000000000000000, 1'b0, 64'h0, 64'h0);
    checks++; if (pcvalid !== 1'b1) begin errors++; $display("FAIL pc1024 got=%b exp=%b", pcvalid, 1'b1); end
  endtask

  task automatic test_opq();
    apply(64'd0, 80'h30F2_2200000000000000, 1'b0, 64'h22, 64'h0);
    tick();
    apply(64'd0, 80'h30F3_3300000000000000, 1'b0, 64'h33, 64'h0);
    tick();
    checks++; if (rm[2] !== 64'h22) begin errors++; $display("FAIL irmov_wb_r2 got=%h exp=%h", rm[2], 64'h22); end
    apply(64'd0, 80'h6023_0000000000000000, 1'b0, 64'h55, 64'h0);
    checks++; if (valA !== 64'h22) begin errors++; $display("FAIL opq_valA got=%h exp=%h", valA, 64'h22); end
    checks++; if (valB !== 64'h33) begin errors++; $display("FAIL opq_valB got=%h exp=%h", valB, 64'h33); end
    tick();
    checks++; if (rm[3] !== 64'h55) begin errors++; $display("FAIL opq_wb_r3 got=%h exp=%h", rm[3], 64'h55); end
    checks++; if (valB !== 64'h55) begin errors++; $display("FAIL opq_valB_after got=%h exp=%h", valB, 64'h55); end
    checks++; if (rm[2] !== 64'h22) begin errors++; $display("FAIL opq_r2_kept got=%h exp=%h", rm[2], 64'h22); end
  endtask

  task automatic test_cmov();
    apply(64'd0, 80'h2101_0000000000000000, 1'b0, 64'h77, 64'h0);
    tick();
    checks++; if (rm[1] !== 64'd0) begin errors++; $display("FAIL cmov_cnd0 got=%h exp=%h", rm[1], 64'd0); end
    apply(64'd0, 80'h2101_0000000000000000, 1'b1, 64'h77, 64'h0);
    tick();
    checks++; if (rm[1] !== 64'h77) begin errors++; $display("FAIL cmov_cnd1 got=%h exp=%h", rm[1], 64'h77); end
  endtask

  task automatic test_stack();
    apply(64'd0, 80'h8000_1000000000000000, 1'b0, 64'h1F8, 64'h0);
    checks++; if (valB !== 64'd0) begin errors++; $display("FAIL call_valB got=%h exp=%h", valB, 64'd0); end
    tick();
    checks++; if (rm[4] !== 64'h1F8) begin errors++; $display("FAIL call_rsp got=%h exp=%h", rm[4], 64'h1F8); end
    apply(64'd0, 80'hB04F_0000000000000000, 1'b0, 64'h8, 64'h99);
    checks++; if (valA !== 64'h1F8) begin errors++; $display("FAIL pop_valA got=%h exp=%h", valA, 64'h1F8); end
    checks++; if (valB !== 64'h1F8) begin errors++; $display("FAIL pop_valB got=%h exp=%h", valB, 64'h1F8); end
    tick();
    checks++; if (rm[4] !== 64'h99) begin errors++; $display("FAIL pop_rsp got=%h exp=%h", rm[4], 64'h99); end
  endtask

  task automatic test_no_write();
    // halt and invalid icodes never change state
    apply(64'd0, 80'h0012_0000000000000000, 1'b1, 64'hAA, 64'hBB);
    tick();
    apply(64'd0, 80'hD012_0000000000000000, 1'b1, 64'hAA, 64'hBB);
    tick();
    checks++; if ({rm[1], rm[2]} !== {64'h77, 64'h22}) begin errors++; $display("FAIL nowrite_regs got=%h exp=%h", {rm[1], rm[2]}, {64'h77, 64'h22}); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (rm[i] !== 64'd0) begin
        errors++;
        $display("FAIL async_reset_reg%0d got=%h exp=%h", i, rm[i], 64'd0);
      end
    end
    // A write presented during reset is suppressed.
    apply(64'd0, 80'h30F5_0000000000000000, 1'b0, 64'h5A5A, 64'h0);
    tick();
    checks++; if (rm[5] !== 64'd0) begin errors++; $display("FAIL reset_suppress got=%h exp=%h", rm[5], 64'd0); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch_lengths();
    test_invalid_halt_range();
    test_opq();
    test_cmov();
    test_stack();
    test_no_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
